// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
//   AN_OFF       : per-digit anode level that turns a digit off (active-low anodes)
//   BLANK_ON     : decoder blank level that darkens all segments
//   BLINK_FRAMES : frames per blink half-period
//   buf_state_t  : display load buffer state (IDLE / PENDING)
package sevseg_pkg;

  localparam logic        AN_OFF       = 1'b1;
  localparam logic        BLANK_ON     = 1'b1;
  localparam int unsigned BLINK_FRAMES = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } buf_state_t;

endpackage : sevseg_pkg

// File: rtl/sevseg_prescaler.sv
// Enable-gated modulo-DIV counter; tick_c is high on the enabled cycle where
// the count sits at DIV-1, after which the count wraps to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable
//   tick_c     : combinational terminal-count strobe
module sevseg_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick_c = en && (count == CNT_W'(DIV - 1));

  // Modulo counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule : sevseg_prescaler

// File: rtl/sev_seg_scanner.sv
// Time-multiplexed scan controller for the front-panel seven-segment display.
// Steps through the digits at a fixed refresh rate, presenting each digit's
// value and blank control to the shared decoder. Display loads are double
// buffered and committed only at frame boundaries so a scan is never torn.
// Optional blink support is compiled in with SEVSEG_BLINK_EN.
//   clk, rst_n  : clock, asynchronous active-low reset
//   disp_value  : BCD digits, digit 0 (rightmost) in [3:0]
//   disp_load   : one-cycle load request for disp_value / disp_lz_en
//   disp_lz_en  : leading-zero suppression enable, captured with disp_load
//   disp_busy   : a load is waiting for the next frame boundary
//   disp_ack    : one-cycle pulse when the pending load is committed
//   LED_BCD     : digit value to the decoder
//   dec_blank   : decoder blank (1 = segments off)
//   an          : active-low one-hot digit anodes
//   blink_mask  : per-digit blink enable (SEVSEG_BLINK_EN only)
module sev_seg_scanner
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] disp_value,
  input  logic                    disp_load,
  input  logic                    disp_lz_en,
  output logic                    disp_busy,
  output logic                    disp_ack,
  output logic [3:0]              LED_BCD,
  output logic                    dec_blank,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic                  tick_c;
  logic                  fb_c;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      active;
  logic [VAL_W-1:0]      pending;
  logic                  lz_en;
  logic                  pend_lz;
  buf_state_t            buf_state;
  logic [NUM_DIGITS-1:0] supp_c;
  logic                  zero_run_c;
  logic                  blink_off_c;

  sevseg_prescaler #(.DIV(REFRESH_DIV)) u_refresh (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .tick_c (tick_c)
  );

  // Frame boundary: the tick that wraps the digit index back to 0
  assign fb_c = tick_c && (idx == IDX_W'(NUM_DIGITS - 1));

  // Digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick_c) begin
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Load buffer: pending captures every load, active updates only at fb.
  // A load coinciding with fb commits the old pending and stays PENDING.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_state <= IDLE;
      pending   <= '0;
      pend_lz   <= 1'b0;
      active    <= '0;
      lz_en     <= 1'b0;
      disp_ack  <= 1'b0;
    end else begin
      disp_ack <= 1'b0;
      case (buf_state)
        IDLE: begin
          if (disp_load) begin
            pending   <= disp_value;
            pend_lz   <= disp_lz_en;
            buf_state <= PENDING;
          end
        end
        PENDING: begin
          if (fb_c) begin
            active   <= pending;
            lz_en    <= pend_lz;
            disp_ack <= 1'b1;
          end
          if (disp_load) begin
            pending <= disp_value;
            pend_lz <= disp_lz_en;
          end else if (fb_c) begin
            buf_state <= IDLE;
          end
        end
        default: buf_state <= IDLE;
      endcase
    end
  end

  assign disp_busy = (buf_state == PENDING);

  // Leading-zero map: digit k is dark when it and every digit above it are 0
  always_comb begin
    supp_c     = '0;
    zero_run_c = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_c = zero_run_c & (active[4*k +: 4] == 4'd0);
      supp_c[k]  = lz_en & zero_run_c & (k != 0);
    end
  end

`ifdef SEVSEG_BLINK_EN
  logic blink_tick_c;
  logic blink_phase;

  sevseg_prescaler #(.DIV(BLINK_FRAMES)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (fb_c),
    .tick_c (blink_tick_c)
  );

  // Blink phase: 0 = visible, toggles every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase <= 1'b0;
    end else if (blink_tick_c) begin
      blink_phase <= ~blink_phase;
    end
  end

  assign blink_off_c = blink_phase & blink_mask[idx];
`else
  assign blink_off_c = 1'b0;
`endif

  // Registered decoder/anode outputs, one cycle behind idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= {NUM_DIGITS{AN_OFF}};
      LED_BCD   <= 4'd0;
      dec_blank <= BLANK_ON;
    end else begin
      an        <= ~(NUM_DIGITS'(1) << idx);
      LED_BCD   <= active[{idx, 2'b00} +: 4];
      dec_blank <= supp_c[idx] | blink_off_c;
    end
  end

endmodule : sev_seg_scanner

// File: tb/tb_sev_seg_scanner.sv
// Directed self-checking bench for sev_seg_scanner (4 digits, 4-cycle dwell).
// Optional blink checks are compiled when SEVSEG_BLINK_EN is defined.
module tb_sev_seg_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] disp_value;
  logic        disp_load;
  logic        disp_lz_en;
  logic        disp_busy;
  logic        disp_ack;
  logic [3:0]  LED_BCD;
  logic        dec_blank;
  logic [3:0]  an;
`ifdef SEVSEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int tests;
  int fails;
  int cyc;
  int ack_cnt;
  int ack_snap;

  sev_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_value (disp_value),
    .disp_load  (disp_load),
    .disp_lz_en (disp_lz_en),
    .disp_busy  (disp_busy),
    .disp_ack   (disp_ack),
    .LED_BCD    (LED_BCD),
    .dec_blank  (dec_blank),
`ifdef SEVSEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (disp_ack === 1'b1) ack_cnt++;
  endtask

  task automatic goto_cyc(input int target);
    if (cyc > target) chk("sequence", 32'(cyc), 32'(target));
    while (cyc < target) step();
  endtask

  task automatic load(input logic [15:0] v, input logic lz);
    disp_value = v;
    disp_lz_en = lz;
    disp_load  = 1'b1;
    step();
    disp_load  = 1'b0;
  endtask

  // Digit k of the frame whose commit edge is f is on display at f+4k+1..f+4k+4
  task automatic chk_digit(input int f, input int k, input logic [3:0] led, input logic blank);
    logic [3:0] ea;
    ea = ~(4'b0001 << k);
    goto_cyc(f + 4*k + 2);
    chk($sformatf("an_d%0d_c%0d", k, cyc), 32'(an), 32'(ea));
    chk($sformatf("led_d%0d_c%0d", k, cyc), 32'(LED_BCD), 32'(led));
    chk($sformatf("blank_d%0d_c%0d", k, cyc), 32'(dec_blank), 32'(blank));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'h0000_000f);
    chk({tag, "_blank"}, 32'(dec_blank), 32'd1);
    chk({tag, "_led"}, 32'(LED_BCD), 32'd0);
    chk({tag, "_busy"}, 32'(disp_busy), 32'd0);
    chk({tag, "_ack"}, 32'(disp_ack), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_an;
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    ack_cnt    = 0;
    rst_n      = 1'b0;
    disp_value = 16'h0000;
    disp_load  = 1'b0;
    disp_lz_en = 1'b0;
`ifdef SEVSEG_BLINK_EN
    blink_mask = 4'b0001;
`endif

    // Reset state and first scan sequence
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_an = ~(4'b0001 << (((i - 1) / 4) % 4));
      chk($sformatf("scan_an_c%0d", i), 32'(an), 32'(exp_an));
    end
    chk("scan_blank", 32'(dec_blank), 32'd0);
    chk("scan_led", 32'(LED_BCD), 32'd0);

    // Mid-frame load: busy until the wrap at 32, then 4,3,2,1
    ack_snap = ack_cnt;
    load(16'h1234, 1'b0);
    chk("busy_rise", 32'(disp_busy), 32'd1);
    chk("no_early_ack", 32'(disp_ack), 32'd0);
    goto_cyc(31);
    chk("busy_hold", 32'(disp_busy), 32'd1);
    step();
    chk("ack_1234", 32'(disp_ack), 32'd1);
    chk("busy_clear", 32'(disp_busy), 32'd0);
    step();
    chk("ack_one_cycle", 32'(disp_ack), 32'd0);
    chk_digit(32, 0, 4'h4, 1'b0);
    chk_digit(32, 1, 4'h3, 1'b0);
    chk_digit(32, 2, 4'h2, 1'b0);
    chk_digit(32, 3, 4'h1, 1'b0);
    chk("ack_count_1234", 32'(ack_cnt - ack_snap), 32'd1);

    // Leading-zero suppression of 0042
    goto_cyc(50);
    load(16'h0042, 1'b1);
    chk_digit(64, 0, 4'h2, 1'b0);
    chk_digit(64, 1, 4'h4, 1'b0);
    chk_digit(64, 2, 4'h0, 1'b1);
    chk_digit(64, 3, 4'h0, 1'b1);

    // All-zero value: only digit 0 stays lit
    goto_cyc(80);
    load(16'h0000, 1'b1);
    chk_digit(96, 0, 4'h0, 1'b0);
    chk_digit(96, 1, 4'h0, 1'b1);
    chk_digit(96, 2, 4'h0, 1'b1);
    chk_digit(96, 3, 4'h0, 1'b1);

    // Hex digits pass through; an inner zero below a nonzero digit stays lit
    goto_cyc(112);
    load(16'hA0F0, 1'b1);
    chk_digit(128, 0, 4'h0, 1'b0);
    chk_digit(128, 1, 4'hF, 1'b0);
    chk_digit(128, 2, 4'h0, 1'b0);
    chk_digit(128, 3, 4'hA, 1'b0);

    // Back-to-back loads: last write wins, single ack
    goto_cyc(144);
    ack_snap = ack_cnt;
    load(16'h1111, 1'b0);
    load(16'h2222, 1'b0);
    goto_cyc(160);
    chk("ack_2222", 32'(disp_ack), 32'd1);
    chk_digit(160, 0, 4'h2, 1'b0);
    chk_digit(160, 3, 4'h2, 1'b0);
    goto_cyc(175);
    chk("ack_count_b2b", 32'(ack_cnt - ack_snap), 32'd1);

    // Load on the frame wrap: old pending commits, new one at next wrap
    goto_cyc(180);
    ack_snap = ack_cnt;
    load(16'h5555, 1'b0);
    goto_cyc(191);
    load(16'h6666, 1'b0);
    chk("ack_fb_first", 32'(disp_ack), 32'd1);
    chk("busy_fb_stays", 32'(disp_busy), 32'd1);
    chk_digit(192, 0, 4'h5, 1'b0);
    goto_cyc(208);
    chk("ack_fb_second", 32'(disp_ack), 32'd1);
    chk("busy_fb_clear", 32'(disp_busy), 32'd0);
    chk_digit(208, 0, 4'h6, 1'b0);
    chk("ack_count_fb", 32'(ack_cnt - ack_snap), 32'd2);

    // Reset mid-frame with a load pending: discarded, no ack
    goto_cyc(220);
    load(16'h7777, 1'b1);
    goto_cyc(224);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    step();
    step();
    rst_n    = 1'b1;
    cyc      = 0;
    ack_snap = ack_cnt;
    goto_cyc(17);
    chk("no_ack_after_reset", 32'(ack_cnt - ack_snap), 32'd0);
    chk("busy_after_reset", 32'(disp_busy), 32'd0);
    chk_digit(16, 0, 4'h0, 1'b0);
    chk_digit(16, 3, 4'h0, 1'b0);

`ifdef SEVSEG_BLINK_EN
    // Digit 0 blinks: dark for frames 64..127 after reset, visible otherwise
    chk_digit(1008, 0, 4'h0, 1'b0);
    chk_digit(1024, 0, 4'h0, 1'b1);
    chk_digit(1024, 1, 4'h0, 1'b0);
    chk_digit(2032, 0, 4'h0, 1'b1);
    chk_digit(2048, 0, 4'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sev_seg_scanner
